// File: rtl/mod_key_seq_pkg.sv
// Shared definitions for the round-key sequencer: FSM states, AES-256 key
// schedule constants and the direction encoding.
package mod_key_seq_pkg;

    localparam int AES_DATA_WIDTH = 128;
    localparam int AES_ADDR_WIDTH = 4;
    localparam int AES_LAST_KEY   = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_PRESENT,
        ST_DONE
    } state_t;

    typedef enum logic {
        DIR_ENC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

endpackage

// File: rtl/mod_key_seq.sv
// Round-key sequencer: walks the key ROM ascending (encrypt) or descending
// (decrypt) and hands each key to the round datapath with a valid/ready handshake.
module mod_key_seq
    import mod_key_seq_pkg::*;
#(
    parameter int DATA_WIDTH = AES_DATA_WIDTH,
    parameter int ADDR_WIDTH = AES_ADDR_WIDTH,
    parameter int LAST_KEY   = AES_LAST_KEY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  decrypt,
    input  logic                  abort,
    output logic                  rom_rd_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] key_out,
    output logic [ADDR_WIDTH-1:0] key_round,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LAST_KEY);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    state_t                state, state_nxt;
    dir_t                  dir, dir_nxt;
    logic [ADDR_WIDTH-1:0] idx, idx_nxt;
    logic                  xfer, final_idx;

    assign xfer      = key_valid & key_ready;
    assign final_idx = (dir == DIR_ENC) ? (idx == LAST_IDX) : (idx == '0);

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        idx_nxt   = idx;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    dir_nxt   = dir_t'(decrypt);
                    idx_nxt   = decrypt ? LAST_IDX : '0;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH:   state_nxt = ST_WAIT;
            ST_WAIT:    state_nxt = ST_PRESENT;
            ST_PRESENT: begin
                if (xfer) begin
                    if (final_idx) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt   = (dir == DIR_ENC) ? idx + ONE : idx - ONE;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        // Abort freezes the index too, so idx always equals the last address read.
        if (abort && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
            idx_nxt   = idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dir       <= DIR_ENC;
            idx       <= '0;
            key_out   <= '0;
            key_round <= '0;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
            idx   <= idx_nxt;
            if (state == ST_WAIT && !abort) begin
                key_out   <= rom_data;
                key_round <= idx;
            end
        end
    end

    // idx only moves on entry to FETCH, so it doubles as the held ROM address.
    assign rom_addr  = idx;
    assign rom_rd_en = (state == ST_FETCH);
    assign key_valid = (state == ST_PRESENT);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_mod_key_seq.sv
// Bench for mod_key_seq: scenario table, hand-written corner sequences and
// randomized runs, all checked by a transaction-level reference monitor.
module tb_mod_key_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, decrypt = 1'b0, abort = 1'b0, key_ready = 1'b1;
    logic         rom_rd_en, key_valid, busy, done;
    logic [3:0]   rom_addr, key_round;
    logic [127:0] rom_data = '0, key_out;

    mod_key_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .abort(abort),
        .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .key_out(key_out), .key_round(key_round), .key_valid(key_valid),
        .key_ready(key_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int nchk = 0, nfail = 0;
    int ntx = 0, ndone = 0, cyc = 0;
    logic [7:0] seed = 8'h00;

    function automatic logic [127:0] word(input int n);
        logic [7:0] b;
        b = 8'(n) ^ seed;
        return {16{b}};
    endfunction

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Key ROM: word n is byte (n ^ seed) replicated, one-cycle read latency.
    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= word(int'(rom_addr));
        cyc <= cyc + 1;
    end

    // Reference monitor: expected key order as a queue, timing from event gaps.
    int   expq[$];
    bit   active = 0, prev_stall = 0;
    int   last_ev = 0, last_tx = -10, stalls = 0;
    logic [3:0]   prev_round;
    logic [127:0] prev_out;

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            active = 0; prev_stall = 0; stalls = 0;
        end else begin
            if (prev_stall) begin
                chk(key_valid && key_round == prev_round && key_out == prev_out, "stall_hold",
                    {key_valid, key_round}, {1'b1, prev_round});
                chk(!rom_rd_en, "stall_no_read", rom_rd_en, 0);
            end
            prev_stall = key_valid && !key_ready && !abort;
            if (prev_stall) begin
                prev_round = key_round; prev_out = key_out; stalls++;
            end
            if (rom_rd_en && active && expq.size() > 0)
                chk(int'(rom_addr) == expq[0], "rom_addr", rom_addr, expq[0]);
            if (done) begin
                chk(active && expq.size() == 0 && last_tx == cyc - 1, "done_pulse",
                    cyc - last_tx, 1);
                active = 0;
                ndone++;
            end
            if (busy && abort) begin
                active = 0;
                expq.delete();
            end else if (key_valid && key_ready) begin
                if (!active || expq.size() == 0) begin
                    chk(0, "unexpected_xfer", key_round, 0);
                end else begin
                    int e;
                    e = expq.pop_front();
                    chk(int'(key_round) == e, "key_round", key_round, e);
                    chk(key_out == word(e), "key_out", key_out, word(e));
                    chk(cyc - last_ev == 3 + stalls, "xfer_gap", cyc - last_ev, 3 + stalls);
                end
                last_ev = cyc; last_tx = cyc; stalls = 0;
                ntx++;
            end
            if (start && !busy && !abort) begin
                expq.delete();
                for (int i = 0; i <= 14; i++) expq.push_back(decrypt ? 14 - i : i);
                active = 1; last_ev = cyc; stalls = 0;
            end
        end
    end

    typedef struct {
        bit dec;
        int stall_at, stall_len, abort_at, start_at;
        int exp_tx, exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic run_case(input vec_t v, input int id);
        int tx0, d0, stall_left, guard, k;
        tx0 = ntx; d0 = ndone; stall_left = v.stall_len; guard = 0;
        @(posedge clk); #1;
        start = 1; decrypt = v.dec; key_ready = 1; abort = 0;
        @(posedge clk); #1;
        start = 0; decrypt = ~v.dec;
        while (busy && guard < 400) begin
            key_ready = 1; abort = 0; start = 0;
            if (key_valid) begin
                k = ntx - tx0;
                if (k == v.stall_at && stall_left > 0) begin key_ready = 0; stall_left--; end
                if (k == v.abort_at) abort = 1;
                if (k == v.start_at) begin start = 1; decrypt = ~v.dec; end
            end
            @(posedge clk); #1;
            guard++;
        end
        abort = 0; start = 0; key_ready = 1;
        chk(guard < 400, $sformatf("case%0d_timeout", id), guard, 400);
        chk(ntx - tx0 == v.exp_tx, $sformatf("case%0d_xfers", id), ntx - tx0, v.exp_tx);
        chk(ndone - d0 == v.exp_done, $sformatf("case%0d_dones", id), ndone - d0, v.exp_done);
        chk(!key_valid && !busy, $sformatf("case%0d_idle", id), {key_valid, busy}, 0);
    endtask

    task automatic chk_zero(input string name);
        chk(!rom_rd_en && rom_addr == 0 && key_out == 0 && key_round == 0 && !key_valid && !busy && !done,
            name, {rom_rd_en, rom_addr, key_round, key_valid, busy, done}, 0);
        chk(key_out == 0, {name, "_key_out"}, key_out, 0);
    endtask

    initial begin
        vec_t vr;
        int guard;
        //           dec stall_at len abort_at start_at tx done
        vecs[0] = '{0, -1, 0, -1, -1, 15, 1};
        vecs[1] = '{1, -1, 0, -1, -1, 15, 1};
        vecs[2] = '{0,  3, 5, -1, -1, 15, 1};
        vecs[3] = '{0, -1, 0, -1,  7, 15, 1};
        vecs[4] = '{0, -1, 0,  5, -1,  5, 0};
        vecs[5] = '{0, -1, 0, 14, -1, 14, 0};
        vecs[6] = '{1, -1, 0, 14, -1, 14, 0};
        vecs[7] = '{1,  0, 3, -1, -1, 15, 1};

        seed = 8'($urandom) | 8'h40;
        #12 chk_zero("reset_state");
        #11 rst_n = 1;

        for (int i = 0; i < 8; i++) run_case(vecs[i], i);

        // Abort and start together in IDLE: abort wins.
        @(posedge clk); #1; start = 1; abort = 1;
        @(posedge clk); #1; start = 0; abort = 0;
        chk(!busy && !rom_rd_en, "abort_start_idle", {busy, rom_rd_en}, 0);
        @(posedge clk); #1;
        chk(!busy, "abort_start_idle2", busy, 0);

        // Reset asynchronously in FETCH of a descending run.
        @(posedge clk); #1; start = 1; decrypt = 1;
        @(posedge clk); #1; start = 0;
        chk(rom_rd_en && rom_addr == 14, "fetch_before_reset", {rom_rd_en, rom_addr}, {1'b1, 4'd14});
        #2 rst_n = 0;
        #1 chk_zero("async_reset");
        #10 rst_n = 1;
        repeat (5) @(posedge clk);
        #1 chk(!busy && !key_valid && !rom_rd_en, "idle_after_reset", {busy, key_valid, rom_rd_en}, 0);
        run_case(vecs[0], 8);

        // Randomized runs: random backpressure, stray starts, rare aborts.
        for (int r = 0; r < 12; r++) begin
            @(posedge clk); #1;
            start = 1; decrypt = 1'($urandom); abort = 0; key_ready = 1;
            @(posedge clk); #1;
            guard = 0;
            while (busy && guard < 600) begin
                start     = ($urandom % 10) == 0;
                decrypt   = 1'($urandom);
                key_ready = ($urandom % 4) != 0;
                abort     = ($urandom % 90) == 0;
                @(posedge clk); #1;
                guard++;
            end
            start = 0; abort = 0; key_ready = 1;
            chk(guard < 600, "rand_timeout", guard, 600);
            chk(expq.size() == 0, "rand_queue_drained", expq.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/mod_key_seq.md
MOD_KEY_SEQ -- requirements
Module: mod_key_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 128, width of one round key (a full 4x4 byte matrix).
REQ-002 Parameter ADDR_WIDTH, default 4, key ROM address width.
REQ-003 Parameter LAST_KEY, default 14, index of the final round key; keys 0..LAST_KEY are served (15 keys for AES-256).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  one-cycle request to begin a key sequence; honoured only in IDLE.
REQ-007 decrypt  input  1  direction, sampled only on the cycle start is honoured: 0 = ascending 0..LAST_KEY, 1 = descending LAST_KEY..0.
REQ-008 abort  input  1  terminates any sequence in progress.
REQ-009 rom_rd_en  output  1  read strobe to the key ROM.
REQ-010 rom_addr  output  ADDR_WIDTH  key ROM address.
REQ-011 rom_data  input  DATA_WIDTH  key ROM read data, valid the cycle after rom_rd_en.
REQ-012 key_out  output  DATA_WIDTH  registered round key presented to the round datapath.
REQ-013 key_round  output  ADDR_WIDTH  index of the key currently on key_out.
REQ-014 key_valid  output  1  key_out/key_round hold a valid key.
REQ-015 key_ready  input  1  consumer accepts the key; a transfer occurs when key_valid and key_ready are both high.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when a sequence completes normally.

Function
REQ-018 FSM states: IDLE, FETCH, WAIT, PRESENT, DONE.
REQ-019 IDLE: start=1 loads the index register with 0 (decrypt=0) or LAST_KEY (decrypt=1), latches the direction, and moves to FETCH; start=0 stays in IDLE.
REQ-020 FETCH: rom_rd_en=1 and rom_addr=index for exactly one cycle, then WAIT.
REQ-021 WAIT: key_out is loaded from rom_data at the closing edge and key_round from index, then PRESENT.
REQ-022 PRESENT: key_valid=1; key_out and key_round stay stable until transfer.
REQ-023 PRESENT with transfer and index not final: step index (+1 ascending, -1 descending), then FETCH.
REQ-024 PRESENT with transfer and index final (LAST_KEY ascending, 0 descending): go to DONE.
REQ-025 DONE: done=1 for one cycle, then IDLE.
REQ-026 Latency: key_valid rises 3 cycles after the edge that samples start; with key_ready held high, consecutive keys are 3 cycles apart; a full 15-key sequence takes 45 cycles to the final transfer, and done follows on the next cycle.
REQ-027 The index never wraps: it never exceeds LAST_KEY ascending and never goes below 0 descending.
REQ-028 start while busy is ignored, and decrypt is not re-sampled.
REQ-029 abort=1 in any non-IDLE state forces IDLE at the next edge: key_valid drops, no done pulse, and the ROM read in flight is discarded.
REQ-030 Simultaneous abort and start in IDLE: abort wins and the FSM stays in IDLE.
REQ-031 abort in the same cycle as the final transfer: abort wins and done is not pulsed.
REQ-032 rom_rd_en=0 in all states except FETCH; rom_addr holds its last value when not reading.
REQ-033 key_valid is a registered function of state, with no combinational path from key_ready.

Reset
REQ-034 rst_n low asynchronously forces IDLE and clears the index, key_out, key_round, key_valid, rom_rd_en, rom_addr, busy, done and the direction register to 0.
REQ-035 Reset asserted mid-sequence abandons the sequence with no done pulse; after release the block waits for a new start.

Structure
REQ-036 A shared package holds the FSM state enum, the AES-256 constants (DATA_WIDTH=128, ADDR_WIDTH=4, LAST_KEY=14) and the direction encoding.
REQ-037 The block is a single FSM module with no sub-module; in the top level, the key ROM (mod_romKey) is instantiated beside it, not inside it.

Verification
REQ-038 Encrypt, key_ready tied high, ROM word n = n replicated: start -> 15 transfers with key_round 0..14 and key_out matching, 3 cycles apart, then done one cycle after the last transfer.
REQ-039 Decrypt, same stimulus: key_round 14 down to 0 with matching data; index never goes below 0; exactly one done pulse.
REQ-040 Backpressure: key_ready low for 5 cycles at key 3 -> key_valid and key_out stable for those cycles, and no rom_rd_en until the transfer.
REQ-041 start pulsed at key 7 of a running sequence -> ignored, and the sequence finishes normally at key 14.
REQ-042 abort at key 5 (and a separate run with abort on the final transfer) -> IDLE next cycle, key_valid=0, no done; a new start then runs cleanly from key 0.
REQ-043 rst_n dropped mid-FETCH, asynchronous to clk -> all outputs 0 immediately; after release the FSM stays in IDLE until start.
